// File: rtl/ext_bus_pkg.sv
// rtl/ext_bus_pkg.sv - shared types and defaults for the external data-bus sequencer
package ext_bus_pkg;

    localparam int DW_DEFAULT   = 16;
    localparam int WAIT_DEFAULT = 2;
    localparam int TURN_DEFAULT = 1;

    // Level of nrd/nwr when no strobe is asserted
    localparam logic STROBE_OFF = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_TURN
    } BusState;

endpackage

// File: rtl/ext_data_bus_seq_if.sv
// rtl/ext_data_bus_seq_if.sv - request handshake and pad-side bus signals of the sequencer
interface ext_data_bus_seq_if import ext_bus_pkg::*; #(
    parameter int DW = DW_DEFAULT
) ();

    logic          req;
    logic          we;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;
    logic          busy;
    logic [DW-1:0] pad_a;
    logic [DW-1:0] pad_tn;
    logic [DW-1:0] pad_zi;
    logic          nrd;
    logic          nwr;

    // Sequencer side: takes requests and pad return data, drives pads and strobes
    modport slave (
        input  req, we, wdata, pad_zi,
        output ack, rdata, busy, pad_a, pad_tn, nrd, nwr
    );

    // Requester / pad-model side
    modport master (
        output req, we, wdata, pad_zi,
        input  ack, rdata, busy, pad_a, pad_tn, nrd, nwr
    );

endinterface

// File: rtl/ext_bus_wait_ctr.sv
// rtl/ext_bus_wait_ctr.sv - 4-bit loadable down-counter with zero flag for WAIT and TURN timing
module ext_bus_wait_ctr (
    input  logic       MasterClock,
    input  logic       RESET,
    input  logic       load,
    input  logic [3:0] loadValue,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] count;

    // Load has priority; decrement saturates at zero so STROBE can idle here while extended
    always_ff @(posedge MasterClock or posedge RESET) begin
        if (RESET) begin
            count <= 4'd0;
        end else if (load) begin
            count <= loadValue;
        end else if (dec && (count != 4'd0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == 4'd0);

endmodule

// File: rtl/ext_data_bus_seq.sv
// rtl/ext_data_bus_seq.sv - external data-bus cycle sequencer (optional EXT_READY_EN ready extension)
module ext_data_bus_seq import ext_bus_pkg::*; #(
    parameter int DW   = DW_DEFAULT,
    parameter int WAIT = WAIT_DEFAULT,
    parameter int TURN = TURN_DEFAULT
) (
    input  logic                    MasterClock,
    input  logic                    RESET,
    ext_data_bus_seq_if.slave       bus
`ifdef EXT_READY_EN
    ,
    input  logic                    ext_ready
`endif
);

    // Counter preloads: the counter reaches zero on the last cycle of the phase
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT - 1);
    localparam logic [3:0] TURN_LOAD = (TURN > 0) ? 4'(TURN - 1) : 4'd0;

    BusState       state;
    BusState       nextState;
    logic          isWrite;
    logic [DW-1:0] padA;
    logic [DW-1:0] padTn;
    logic [DW-1:0] rdataReg;
    logic          nrdReg;
    logic          nwrReg;
    logic          ackReg;
    logic          busyReg;

    logic [DW-1:0] nextTn;
    logic          nextNrd;
    logic          nextNwr;
    logic          nextAck;
    logic          accept;
    logic          captureRead;
    logic          ctrLoad;
    logic [3:0]    ctrValue;
    logic          ctrDec;
    logic          ctrZero;
    logic          readyOk;

`ifdef EXT_READY_EN
    logic readyMeta;
    logic readySync;

    // Two-flop synchroniser; resets to ready so a tied-high ext_ready never stretches STROBE
    always_ff @(posedge MasterClock or posedge RESET) begin
        if (RESET) begin
            readyMeta <= 1'b1;
            readySync <= 1'b1;
        end else begin
            readyMeta <= ext_ready;
            readySync <= readyMeta;
        end
    end

    assign readyOk = readySync;
`else
    assign readyOk = 1'b1;
`endif

    ext_bus_wait_ctr u_wait_ctr (
        .MasterClock (MasterClock),
        .RESET       (RESET),
        .load        (ctrLoad),
        .loadValue   (ctrValue),
        .dec         (ctrDec),
        .zero        (ctrZero)
    );

    // Next state and next registered pad/strobe values for the coming cycle
    always_comb begin
        nextState   = state;
        nextTn      = '0;
        nextNrd     = STROBE_OFF;
        nextNwr     = STROBE_OFF;
        nextAck     = 1'b0;
        accept      = 1'b0;
        captureRead = 1'b0;
        ctrLoad     = 1'b0;
        ctrValue    = 4'd0;
        ctrDec      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req) begin
                    accept    = 1'b1;
                    nextState = ST_SETUP;
                    nextTn    = {DW{bus.we}};
                end
            end
            ST_SETUP: begin
                nextState = ST_STROBE;
                ctrLoad   = 1'b1;
                ctrValue  = WAIT_LOAD;
                nextTn    = {DW{isWrite}};
                nextNrd   = isWrite ? STROBE_OFF : 1'b0;
                nextNwr   = isWrite ? 1'b0 : STROBE_OFF;
            end
            ST_STROBE: begin
                nextTn = {DW{isWrite}};
                if (ctrZero && readyOk) begin
                    nextState   = ST_HOLD;
                    nextAck     = 1'b1;
                    // pad_zi now carries the pin value seen during the strobe, so rdata is valid with ack
                    captureRead = !isWrite;
                end else begin
                    ctrDec  = 1'b1;
                    nextNrd = isWrite ? STROBE_OFF : 1'b0;
                    nextNwr = isWrite ? 1'b0 : STROBE_OFF;
                end
            end
            ST_HOLD: begin
                if (!isWrite && (TURN > 0)) begin
                    nextState = ST_TURN;
                    ctrLoad   = 1'b1;
                    ctrValue  = TURN_LOAD;
                end else begin
                    nextState = ST_IDLE;
                end
            end
            ST_TURN: begin
                if (ctrZero) begin
                    nextState = ST_IDLE;
                end else begin
                    ctrDec = 1'b1;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // State and output registers; reset releases the bus at once
    always_ff @(posedge MasterClock or posedge RESET) begin
        if (RESET) begin
            state    <= ST_IDLE;
            isWrite  <= 1'b0;
            padA     <= '0;
            padTn    <= '0;
            rdataReg <= '0;
            nrdReg   <= STROBE_OFF;
            nwrReg   <= STROBE_OFF;
            ackReg   <= 1'b0;
            busyReg  <= 1'b0;
        end else begin
            state   <= nextState;
            padTn   <= nextTn;
            nrdReg  <= nextNrd;
            nwrReg  <= nextNwr;
            ackReg  <= nextAck;
            busyReg <= (nextState != ST_IDLE);
            if (accept) begin
                isWrite <= bus.we;
                if (bus.we) begin
                    padA <= bus.wdata;
                end
            end
            if (captureRead) begin
                rdataReg <= ~bus.pad_zi;
            end
        end
    end

    assign bus.pad_a  = padA;
    assign bus.pad_tn = padTn;
    assign bus.rdata  = rdataReg;
    assign bus.nrd    = nrdReg;
    assign bus.nwr    = nwrReg;
    assign bus.ack    = ackReg;
    assign bus.busy   = busyReg;

endmodule

// File: tb/tb_ext_data_bus_seq.sv
// tb/tb_ext_data_bus_seq.sv - scoreboard bench for ext_data_bus_seq
module tb_ext_data_bus_seq;

    localparam int DW = 16;
    localparam int W0 = 2;
    localparam int T0 = 1;
    localparam int W1 = 1;

    typedef struct {
        bit          isRead;
        logic [15:0] data;
    } SbEntry;

    logic MasterClock = 1'b0;
    logic RESET       = 1'b1;
    int   testsRun    = 0;
    int   testsFailed = 0;
    SbEntry q0[$];
    SbEntry q1[$];
    SbEntry e0;
    SbEntry e1;

    always #5 MasterClock = ~MasterClock;

`ifdef EXT_READY_EN
    logic extReady  = 1'b1;
    logic readyHigh = 1'b1;
`endif

    ext_data_bus_seq_if #(.DW(DW)) bus0 ();
    ext_data_bus_seq_if #(.DW(DW)) bus1 ();

    ext_data_bus_seq #(.DW(DW), .WAIT(W0), .TURN(T0)) u0 (
        .MasterClock (MasterClock),
        .RESET       (RESET),
        .bus         (bus0)
`ifdef EXT_READY_EN
        ,
        .ext_ready   (extReady)
`endif
    );

    ext_data_bus_seq #(.DW(DW), .WAIT(W1), .TURN(T0)) u1 (
        .MasterClock (MasterClock),
        .RESET       (RESET),
        .bus         (bus1)
`ifdef EXT_READY_EN
        ,
        .ext_ready   (readyHigh)
`endif
    );

    task automatic tick();
        @(posedge MasterClock);
        #1;
    endtask

    // Scoreboard and strobe-exclusion monitor for u0
    always @(negedge MasterClock) begin
        if (!RESET && bus0.ack === 1'b1) begin
            testsRun++;
            if (q0.size() == 0) begin
                testsFailed++;
                $display("FAIL sb0_unexpected_ack got ack=1 want no pending access");
            end else begin
                e0 = q0.pop_front();
                if (e0.isRead && bus0.rdata !== e0.data) begin
                    testsFailed++;
                    $display("FAIL sb0_rdata got %h want %h", bus0.rdata, e0.data);
                end else if (!e0.isRead && bus0.pad_a !== e0.data) begin
                    testsFailed++;
                    $display("FAIL sb0_pad_a got %h want %h", bus0.pad_a, e0.data);
                end
            end
        end
        if (bus0.nrd !== 1'b1 || bus0.nwr !== 1'b1) begin
            testsRun++;
            if (bus0.nrd === 1'b0 && bus0.nwr === 1'b0) begin
                testsFailed++;
                $display("FAIL strobe_exclusive got nrd=0 nwr=0 want at most one low");
            end
        end
    end

    // Scoreboard for u1 (write data at ack)
    always @(negedge MasterClock) begin
        if (!RESET && bus1.ack === 1'b1) begin
            testsRun++;
            if (q1.size() == 0) begin
                testsFailed++;
                $display("FAIL sb1_unexpected_ack got ack=1 want no pending access");
            end else begin
                e1 = q1.pop_front();
                if (bus1.pad_a !== e1.data) begin
                    testsFailed++;
                    $display("FAIL sb1_pad_a got %h want %h", bus1.pad_a, e1.data);
                end
            end
        end
    end

    // One access on u0 from an IDLE cycle; req is left high for the caller to drop
    task automatic run_access(input bit w, input logic [15:0] d, output int lat,
                              output int nrdLow, output int nwrLow, output bit tnBad, output bit aBad);
        SbEntry e;
        bus0.req   = 1'b1;
        bus0.we    = w;
        bus0.wdata = w ? d : 16'h0000;
        if (!w) bus0.pad_zi = ~d;
        e.isRead = !w;
        e.data   = d;
        q0.push_back(e);
        lat = -1; nrdLow = 0; nwrLow = 0; tnBad = 1'b0; aBad = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (bus0.nrd === 1'b0) nrdLow++;
            if (bus0.nwr === 1'b0) nwrLow++;
            if (bus0.pad_tn !== {16{w}}) tnBad = 1'b1;
            if (w && bus0.pad_a !== d) aBad = 1'b1;
            if (bus0.ack === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus0.req = 1'b0; bus0.we = 1'b0; bus0.wdata = '0; bus0.pad_zi = '1;
        bus1.req = 1'b0; bus1.we = 1'b0; bus1.wdata = '0; bus1.pad_zi = '1;
        RESET = 1'b1;
        repeat (2) tick();
        RESET = 1'b0;
        repeat (2) tick();
        testsRun++; if (bus0.pad_tn !== 16'h0000) begin testsFailed++; $display("FAIL reset_pad_tn got %h want 0000", bus0.pad_tn); end
        testsRun++; if (bus0.pad_a !== 16'h0000) begin testsFailed++; $display("FAIL reset_pad_a got %h want 0000", bus0.pad_a); end
        testsRun++; if (bus0.nrd !== 1'b1 || bus0.nwr !== 1'b1) begin testsFailed++; $display("FAIL reset_strobes got nrd=%b nwr=%b want 1 1", bus0.nrd, bus0.nwr); end
        testsRun++; if (bus0.ack !== 1'b0 || bus0.busy !== 1'b0) begin testsFailed++; $display("FAIL reset_ack_busy got ack=%b busy=%b want 0 0", bus0.ack, bus0.busy); end
        testsRun++; if (bus0.rdata !== 16'h0000) begin testsFailed++; $display("FAIL reset_rdata got %h want 0000", bus0.rdata); end
    endtask

    task automatic test_write();
        int lat, nrdLow, nwrLow;
        bit tnBad, aBad;
        run_access(1'b1, 16'hA5C3, lat, nrdLow, nwrLow, tnBad, aBad);
        bus0.req = 1'b0;
        testsRun++; if (lat != 2 + W0) begin testsFailed++; $display("FAIL write_latency got %0d want %0d", lat, 2 + W0); end
        testsRun++; if (nwrLow != W0) begin testsFailed++; $display("FAIL write_nwr_low got %0d want %0d", nwrLow, W0); end
        testsRun++; if (nrdLow != 0) begin testsFailed++; $display("FAIL write_nrd_low got %0d want 0", nrdLow); end
        testsRun++; if (tnBad || aBad) begin testsFailed++; $display("FAIL write_drive got tnBad=%b aBad=%b want 0 0", tnBad, aBad); end
        tick();
        testsRun++; if (bus0.pad_tn !== 16'h0000 || bus0.busy !== 1'b0) begin testsFailed++; $display("FAIL write_release got tn=%h busy=%b want 0000 0", bus0.pad_tn, bus0.busy); end
    endtask

    task automatic test_read();
        int lat, nrdLow, nwrLow;
        bit tnBad, aBad;
        run_access(1'b0, 16'h1234, lat, nrdLow, nwrLow, tnBad, aBad);
        bus0.req = 1'b0;
        testsRun++; if (lat != 2 + W0) begin testsFailed++; $display("FAIL read_latency got %0d want %0d", lat, 2 + W0); end
        testsRun++; if (nrdLow != W0 || nwrLow != 0) begin testsFailed++; $display("FAIL read_strobes got nrdLow=%0d nwrLow=%0d want %0d 0", nrdLow, nwrLow, W0); end
        testsRun++; if (tnBad) begin testsFailed++; $display("FAIL read_pad_tn got driven want never driven"); end
        tick();
        testsRun++; if (bus0.busy !== 1'b1 || bus0.pad_tn !== 16'h0000) begin testsFailed++; $display("FAIL read_turn got busy=%b tn=%h want 1 0000", bus0.busy, bus0.pad_tn); end
        tick();
        testsRun++; if (bus0.busy !== 1'b0) begin testsFailed++; $display("FAIL read_idle got busy=%b want 0", bus0.busy); end
        run_access(1'b0, 16'h5A0F, lat, nrdLow, nwrLow, tnBad, aBad);
        bus0.req = 1'b0;
        testsRun++; if (lat != 2 + W0) begin testsFailed++; $display("FAIL read2_latency got %0d want %0d", lat, 2 + W0); end
        repeat (2) tick();
    endtask

    task automatic test_read_then_write();
        int lat, nrdLow, nwrLow, setupAt, wlat;
        bit tnBad, aBad, turnBusy, idleBusy;
        logic [15:0] turnTn;
        SbEntry e;
        run_access(1'b0, 16'hC001, lat, nrdLow, nwrLow, tnBad, aBad);
        bus0.we = 1'b1; bus0.wdata = 16'h0F0F;
        e.isRead = 1'b0; e.data = 16'h0F0F;
        q0.push_back(e);
        setupAt = -1; turnBusy = 1'b0; idleBusy = 1'b1; turnTn = 16'hFFFF; wlat = -1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            if (n == 1) begin turnBusy = bus0.busy; turnTn = bus0.pad_tn; end
            if (n == 2) idleBusy = bus0.busy;
            if (bus0.pad_tn === 16'hFFFF) begin setupAt = n; break; end
        end
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (bus0.ack === 1'b1) begin wlat = n; break; end
        end
        bus0.req = 1'b0;
        testsRun++; if (setupAt != 3) begin testsFailed++; $display("FAIL rw_setup_cycle got %0d want 3", setupAt); end
        testsRun++; if (turnBusy !== 1'b1 || turnTn !== 16'h0000) begin testsFailed++; $display("FAIL rw_turn got busy=%b tn=%h want 1 0000", turnBusy, turnTn); end
        testsRun++; if (idleBusy !== 1'b0) begin testsFailed++; $display("FAIL rw_idle got busy=%b want 0", idleBusy); end
        testsRun++; if (wlat != W0 + 1) begin testsFailed++; $display("FAIL rw_write_ack got %0d want %0d", wlat, W0 + 1); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [4];
        int ackAt [4];
        int k;
        bit nrdBad;
        SbEntry e;
        vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'hF00D; vals[3] = 16'h8001;
        k = 0; nrdBad = 1'b0;
        for (int i = 0; i < 4; i++) ackAt[i] = -100;
        bus1.req = 1'b1; bus1.we = 1'b1; bus1.wdata = vals[0];
        e.isRead = 1'b0; e.data = vals[0];
        q1.push_back(e);
        for (int n = 1; n <= 60; n++) begin
            tick();
            if (bus1.nrd !== 1'b1) nrdBad = 1'b1;
            if (bus1.ack === 1'b1) begin
                ackAt[k] = n;
                k++;
                if (k == 4) break;
                bus1.wdata = vals[k];
                e.data = vals[k];
                q1.push_back(e);
            end
        end
        bus1.req = 1'b0;
        testsRun++; if (k != 4) begin testsFailed++; $display("FAIL b2b_ack_count got %0d want 4", k); end
        testsRun++; if (ackAt[0] != 2 + W1) begin testsFailed++; $display("FAIL b2b_first_ack got %0d want %0d", ackAt[0], 2 + W1); end
        for (int i = 1; i < 4; i++) begin
            testsRun++;
            if (ackAt[i] - ackAt[i-1] != 3 + W1) begin testsFailed++; $display("FAIL b2b_ack_spacing[%0d] got %0d want %0d", i, ackAt[i] - ackAt[i-1], 3 + W1); end
        end
        testsRun++; if (nrdBad) begin testsFailed++; $display("FAIL b2b_nrd got low want always 1"); end
        repeat (2) tick();
    endtask

`ifdef EXT_READY_EN
    task automatic test_ext_ready();
        int lat, nrdLow, nwrLow;
        bit tnBad, aBad;
        extReady = 1'b0;
        fork
            begin
                repeat (5) tick();
                extReady = 1'b1;
            end
        join_none
        run_access(1'b0, 16'h7E81, lat, nrdLow, nwrLow, tnBad, aBad);
        bus0.req = 1'b0;
        // ready low c0..c4, seen by the synchroniser output from c7, so HOLD lands on c8
        testsRun++; if (lat != 8) begin testsFailed++; $display("FAIL ready_latency got %0d want 8", lat); end
        testsRun++; if (nrdLow != 6) begin testsFailed++; $display("FAIL ready_nrd_low got %0d want 6", nrdLow); end
        repeat (3) tick();
    endtask
`endif

    task automatic test_reset_mid();
        int acks;
        bus0.req = 1'b1; bus0.we = 1'b1; bus0.wdata = 16'hBEEF;
        tick();
        tick();
        testsRun++; if (bus0.nwr !== 1'b0) begin testsFailed++; $display("FAIL mid_pre_nwr got %b want 0", bus0.nwr); end
        #1 RESET = 1'b1;
        #1;
        testsRun++; if (bus0.pad_tn !== 16'h0000 || bus0.nwr !== 1'b1 || bus0.nrd !== 1'b1) begin testsFailed++; $display("FAIL mid_release got tn=%h nrd=%b nwr=%b want 0000 1 1", bus0.pad_tn, bus0.nrd, bus0.nwr); end
        testsRun++; if (bus0.busy !== 1'b0 || bus0.ack !== 1'b0 || bus0.rdata !== 16'h0000) begin testsFailed++; $display("FAIL mid_state got busy=%b ack=%b rdata=%h want 0 0 0000", bus0.busy, bus0.ack, bus0.rdata); end
        bus0.req = 1'b0;
        tick();
        RESET = 1'b0;
        acks = 0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (bus0.ack === 1'b1) acks++;
        end
        testsRun++; if (acks != 0) begin testsFailed++; $display("FAIL mid_no_ack got %0d want 0", acks); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_read_then_write();
        test_back_to_back();
`ifdef EXT_READY_EN
        test_ext_ready();
`endif
        test_reset_mid();
        testsRun++; if (q0.size() != 0 || q1.size() != 0) begin testsFailed++; $display("FAIL sb_drained got %0d/%0d want 0/0", q0.size(), q1.size()); end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got no finish want finish before 200000");
        $fatal(1);
    end

endmodule
